interleaver_ctrl: RTL and testbench

// Sequencer for the two-stream folding interleaver. Pulls whole N-sample symbol

---
 rtl/interleaver_ctrl.sv | 148 ++++++++++++++
 tb/tb_interleaver_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/interleaver_ctrl.sv
// Sequencer for the two-stream folding interleaver: claims symbol pairs, drives one unbroken
// enable burst per symbol, frames interleaver output. Optional FLUSH state via `ILV_CTRL_FLUSH_EN.
module interleaver_ctrl #(
  parameter int N     = 8,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sym_req,
  input  logic                 abort,
  input  logic                 ilv_valid,
  output logic                 sym_ack,
  output logic                 rd_en,
  output logic [$clog2(N)-1:0] rd_idx,
  output logic                 ilv_enable,
  output logic                 zero_fill,
  output logic                 out_sop,
  output logic                 out_eop,
  output logic [CNT_W-1:0]     sym_done,
  output logic                 framing_err
);

  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             start;
  logic [IDX_W-1:0] out_idx;

`ifdef ILV_CTRL_FLUSH_EN
  localparam int FL_W = IDX_W - 1;
  localparam logic [FL_W-1:0] FL_LAST = FL_W'(N / 2 - 1);
  logic [FL_W-1:0] fcnt;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // start marks a new symbol pair being claimed; it becomes the registered sym_ack
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (sym_req) begin
            state_nxt = RUN;
            start     = 1'b1;
          end
        end
        RUN: begin
          if (rd_idx == IDX_LAST) begin
            if (sym_req) start = 1'b1;
`ifdef ILV_CTRL_FLUSH_EN
            else         state_nxt = FLUSH;
`else
            else         state_nxt = IDLE;
`endif
          end
        end
`ifdef ILV_CTRL_FLUSH_EN
        FLUSH: begin
          if (sym_req) begin
            state_nxt = RUN;
            start     = 1'b1;
          end else if (fcnt == FL_LAST) begin
            state_nxt = IDLE;
          end
        end
`endif
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    rd_en      = 1'b0;
    ilv_enable = 1'b0;
    zero_fill  = 1'b0;
    case (state)
      RUN: begin
        rd_en      = 1'b1;
        ilv_enable = 1'b1;
      end
`ifdef ILV_CTRL_FLUSH_EN
      FLUSH: begin
        ilv_enable = 1'b1;
        zero_fill  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // rd_idx wraps naturally at N-1 since N is a power of two
  always_ff @(posedge clk) begin
    if (reset) begin
      sym_ack <= 1'b0;
      rd_idx  <= '0;
    end else begin
      sym_ack <= start;
      if (abort || start)  rd_idx <= '0;
      else if (state == RUN) rd_idx <= rd_idx + 1'b1;
    end
  end

`ifdef ILV_CTRL_FLUSH_EN
  always_ff @(posedge clk) begin
    if (reset)                                     fcnt <= '0;
    else if (state == FLUSH && state_nxt == FLUSH) fcnt <= fcnt + 1'b1;
    else                                           fcnt <= '0;
  end
`endif

  // Output framing follows ilv_valid alone, independent of the sequencer state
  assign out_sop = ilv_valid & ~reset & (out_idx == '0);
  assign out_eop = ilv_valid & ~reset & (out_idx == IDX_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      out_idx     <= '0;
      sym_done    <= '0;
      framing_err <= 1'b0;
    end else begin
      if (out_eop) sym_done <= sym_done + 1'b1;
      if (abort) begin
        out_idx <= '0;
      end else if (ilv_valid) begin
        out_idx <= out_idx + 1'b1;
      end else begin
        if (out_idx != '0) framing_err <= 1'b1;
        out_idx <= '0;
      end
    end
  end

endmodule

// File: tb/tb_interleaver_ctrl.sv
// Self-checking bench for interleaver_ctrl: behavioural model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_interleaver_ctrl;
  localparam int N     = 8;
  localparam int CNT_W = 16;
`ifdef ILV_CTRL_FLUSH_EN
  localparam int F = 1;
`else
  localparam int F = 0;
`endif

  logic             clk = 1'b0;
  logic             reset, sym_req, abort, ilv_valid;
  logic             sym_ack, rd_en, ilv_enable, zero_fill, out_sop, out_eop, framing_err;
  logic [2:0]       rd_idx;
  logic [CNT_W-1:0] sym_done;

  interleaver_ctrl #(.N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .sym_req(sym_req), .abort(abort), .ilv_valid(ilv_valid),
    .sym_ack(sym_ack), .rd_en(rd_en), .rd_idx(rd_idx), .ilv_enable(ilv_enable),
    .zero_fill(zero_fill), .out_sop(out_sop), .out_eop(out_eop), .sym_done(sym_done),
    .framing_err(framing_err)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 reading a symbol, 2 draining; positions as plain integers
  int m_st = 0, m_idx = 0, m_fl = 0, m_ack = 0, m_oidx = 0, m_done = 0, m_err = 0;

  always @(posedge clk) begin : model
    int nst, nidx, nfl, nack, noidx, ndone, nerr;
    nst = m_st; nidx = m_idx; nfl = 0; nack = 0;
    noidx = m_oidx; ndone = m_done; nerr = m_err;
    if (reset) begin
      nst = 0; nidx = 0; noidx = 0; ndone = 0; nerr = 0;
    end else begin
      if (abort) begin
        nst = 0; nidx = 0;
      end else if (m_st == 0) begin
        if (sym_req) begin nst = 1; nidx = 0; nack = 1; end
      end else if (m_st == 1) begin
        if (m_idx < N - 1) nidx = m_idx + 1;
        else begin
          nidx = 0;
          if (sym_req) nack = 1;
          else nst = (F != 0) ? 2 : 0;
        end
      end else begin
        if (sym_req) begin nst = 1; nack = 1; end
        else if (m_fl == N / 2 - 1) nst = 0;
        else nfl = m_fl + 1;
      end
      if (ilv_valid && m_oidx == N - 1) ndone = (m_done + 1) % (1 << CNT_W);
      if (abort) noidx = 0;
      else if (ilv_valid) noidx = (m_oidx + 1) % N;
      else begin
        if (m_oidx != 0) nerr = 1;
        noidx = 0;
      end
    end
    m_st <= nst; m_idx <= nidx; m_fl <= nfl; m_ack <= nack;
    m_oidx <= noidx; m_done <= ndone; m_err <= nerr;
  end

  always @(negedge clk) begin
    chk("sym_ack", sym_ack, m_ack);
    chk("rd_en", rd_en, m_st == 1);
    chk("rd_idx", rd_idx, m_idx);
    chk("ilv_enable", ilv_enable, m_st != 0);
    chk("zero_fill", zero_fill, m_st == 2);
    chk("out_sop", out_sop, ilv_valid && !reset && m_oidx == 0);
    chk("out_eop", out_eop, ilv_valid && !reset && m_oidx == N - 1);
    chk("sym_done", sym_done, m_done);
    chk("framing_err", framing_err, m_err);
  end

  int cyc_no, en_cnt, rd_cnt, zf_cnt, ack_cnt, sop_cnt, eop_cnt, run_len, max_run, last_ack, spacing_bad;

  task automatic clr();
    cyc_no = 0; en_cnt = 0; rd_cnt = 0; zf_cnt = 0; ack_cnt = 0; sop_cnt = 0; eop_cnt = 0;
    run_len = 0; max_run = 0; last_ack = -1; spacing_bad = 0;
  endtask

  task automatic cyc(input logic r, input logic sr, input logic ab, input logic v);
    @(posedge clk);
    #1;
    reset = r; sym_req = sr; abort = ab; ilv_valid = v;
    @(negedge clk);
    cyc_no++;
    en_cnt += int'(ilv_enable); rd_cnt += int'(rd_en); zf_cnt += int'(zero_fill);
    sop_cnt += int'(out_sop); eop_cnt += int'(out_eop);
    if (ilv_enable) run_len++; else run_len = 0;
    if (run_len > max_run) max_run = run_len;
    if (sym_ack) begin
      ack_cnt++;
      if (last_ack >= 0 && cyc_no - last_ack != N) spacing_bad++;
      last_ack = cyc_no;
    end
  endtask

  initial begin
    int done0;
    logic sr, v, ab, r;
    reset = 1'b1; sym_req = 1'b0; abort = 1'b0; ilv_valid = 1'b0;
    clr();
    repeat (3) cyc(1, 0, 0, 0);
    chk("rst_ilv_enable", ilv_enable, 0);
    chk("rst_rd_idx", rd_idx, 0);
    chk("rst_sym_done", sym_done, 0);
    chk("rst_framing_err", framing_err, 0);

    // single symbol
    clr();
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    chk("lat_rd_en", rd_en, 1);
    chk("lat_sym_ack", sym_ack, 1);
    repeat (20) cyc(0, 0, 0, 0);
    chk("single_en_cycles", en_cnt, 8 + 4 * F);
    chk("single_rd_cycles", rd_cnt, 8);
    chk("single_zf_cycles", zf_cnt, 4 * F);
    chk("single_acks", ack_cnt, 1);

    // three back-to-back symbols with 24 output valids
    clr();
    for (int i = 0; i < 60 && ack_cnt < 3; i++) cyc(0, 1, 0, cyc_no >= 1 && cyc_no < 25);
    repeat (30) cyc(0, 0, 0, cyc_no >= 1 && cyc_no < 25);
    chk("b2b_acks", ack_cnt, 3);
    chk("b2b_ack_spacing", spacing_bad, 0);
    chk("b2b_en_cycles", en_cnt, 24 + 4 * F);
    chk("b2b_burst", max_run, 24 + 4 * F);
    chk("b2b_sop", sop_cnt, 3);
    chk("b2b_eop", eop_cnt, 3);
    chk("b2b_sym_done", sym_done, 3);
    chk("b2b_framing_err", framing_err, 0);

`ifdef ILV_CTRL_FLUSH_EN
    // request arriving in the second flush cycle
    clr();
    cyc(0, 1, 0, 0);
    begin
      bit given = 1'b0;
      for (int i = 0; i < 40; i++) begin
        logic s;
        s = (zf_cnt == 1) && !given;
        if (s) given = 1'b1;
        cyc(0, s, 0, 0);
      end
    end
    chk("flrise_zf_cycles", zf_cnt, 6);
    chk("flrise_en_cycles", en_cnt, 22);
    chk("flrise_burst", max_run, 22);
    chk("flrise_acks", ack_cnt, 2);
`endif

    // abort mid-symbol at rd_idx 5
    clr();
    done0 = int'(sym_done);
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 0, 1);
      if (rd_en && rd_idx == 3'd4) break;
    end
    cyc(0, 0, 1, 1);
    chk("abort_at_idx5", rd_idx, 5);
    cyc(0, 0, 0, 0);
    chk("abort_rd_en", rd_en, 0);
    chk("abort_enable", ilv_enable, 0);
    chk("abort_zero_fill", zero_fill, 0);
    chk("abort_rd_idx", rd_idx, 0);
    repeat (3) cyc(0, 0, 0, 0);
    chk("abort_sym_done", sym_done, done0);
    chk("abort_framing_err", framing_err, 0);
    cyc(0, 1, 1, 0);
    cyc(0, 0, 0, 0);
    chk("abort_wins_enable", ilv_enable, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    chk("restart_rd_idx", rd_idx, 0);
    chk("restart_ack", sym_ack, 1);
    chk("restart_rd_en", rd_en, 1);
    repeat (20) cyc(0, 0, 0, 0);

    // ilv_valid drops after 3 samples
    repeat (3) cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("ferr_set", framing_err, 1);
    cyc(0, 0, 0, 1);
    chk("ferr_next_sop", out_sop, 1);
    repeat (3) cyc(0, 0, 0, 0);
    chk("ferr_sticky", framing_err, 1);

    // randomized traffic
    sr = 1'b0; v = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(5) == 0) sr = ~sr;
      if ($urandom_range(7) == 0) v = ~v;
      ab = ($urandom_range(59) == 0);
      r  = ($urandom_range(399) == 0);
      cyc(r, sr, ab, v);
    end
    cyc(0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
